// File: rtl/GAM_package.sv
// GAM_package: types and constants shared by the memory-layer winner scan.
//   node_vector_T : weight vector stored per node slot (also presented as x)
//   mem_node_rd_T : one node-storage read return (w, m, occupied)
//   scan_state_T  : gam_class_winner_scan FSM states
//   GAM_MW        : default width of the learning count M
package GAM_package;

  localparam int GAM_VEC_W = 32;
  localparam int GAM_MW    = 8;

  typedef logic [GAM_VEC_W-1:0] node_vector_T;

  typedef struct packed {
    node_vector_T      w;
    logic [GAM_MW-1:0] m;
    logic              occupied;
  } mem_node_rd_T;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SCAN    = 3'd1,
    S_DRAIN   = 3'd2,
    S_HANDOFF = 3'd3,
    S_WAIT    = 3'd4,
    S_DONE    = 3'd5
  } scan_state_T;

endpackage

// File: rtl/gam_max_m_select.sv
// gam_max_m_select: registered best-so-far tracker for the class scan.
// Each sampled slot replaces the held best only when it is occupied and
// either nothing is held yet or its M is strictly greater (unsigned), so a
// tie keeps the lower, earlier-seen index.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   clear          : drop the held best (start of a new scan)
//   sample         : occupied/m/w/idx carry a returned slot this cycle
//   occupied,m,w,idx : returned slot contents and its slot index
//   nxt_*          : best including the slot presented this cycle; the
//                    owner can capture the final result on the last sample
module gam_max_m_select
  import GAM_package::*;
#(
  parameter int  NODES = 16,
  parameter int  MW    = GAM_MW,
  localparam int IW    = $clog2(NODES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          sample,
  input  logic          occupied,
  input  logic [MW-1:0] m,
  input  node_vector_T  w,
  input  logic [IW-1:0] idx,
  output logic          nxt_valid,
  output logic [IW-1:0] nxt_idx,
  output logic [MW-1:0] nxt_m,
  output node_vector_T  nxt_w
);

  logic          best_valid;
  logic [IW-1:0] best_idx;
  logic [MW-1:0] best_m;
  node_vector_T  best_w;
  logic          take;

  always_comb begin
    take      = sample && occupied && (!best_valid || (m > best_m));
    nxt_valid = best_valid;
    nxt_idx   = best_idx;
    nxt_m     = best_m;
    nxt_w     = best_w;
    if (take) begin
      nxt_valid = 1'b1;
      nxt_idx   = idx;
      nxt_m     = m;
      nxt_w     = w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      best_valid <= 1'b0;
      best_idx   <= '0;
      best_m     <= '0;
      best_w     <= '0;
    end else if (sample) begin
      best_valid <= nxt_valid;
      best_idx   <= nxt_idx;
      best_m     <= nxt_m;
      best_w     <= nxt_w;
    end
  end

endmodule

// File: rtl/gam_class_winner_scan.sv
// gam_class_winner_scan: scans all node slots of one class in node storage,
// picks the occupied node with the largest learning count M (lowest index on
// a tie), presents its weights as x and the class as c to the associative
// layer, and runs the assoc_learning_start/assoc_learning_done handshake.
//
// Handshake: scan_start is a request sampled only in IDLE (ignored, not
// queued, while busy); scan_done is a one-cycle completion pulse with
// found/winner_* valid alongside; assoc_learning_start is a one-cycle pulse
// and assoc_learning_done is a level sampled only in WAIT.
//
// Ports: scan_start/scan_class/scan_key_response request; busy, scan_done,
// found, winner_idx, winner_m result; rd_en/rd_class/rd_idx node-storage read
// with rd_w/rd_m/rd_occupied returning one cycle later; x/c/key_response and
// assoc_learning_start/assoc_learning_done toward the associative layer;
// dbg_state exposes the FSM state.
//
// Optional: define GAM_ASSOC_TIMEOUT_EN to add parameter TIMEOUT and output
// timeout_err; WAIT then gives up after TIMEOUT cycles without done.
module gam_class_winner_scan
  import GAM_package::*;
#(
  parameter int NODES   = 16,
  parameter int CLASSES = 16,
  parameter int MW      = GAM_MW
`ifdef GAM_ASSOC_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     scan_start,
  input  int                       scan_class,
  input  logic                     scan_key_response,
  output logic                     busy,
  output logic                     scan_done,
  output logic                     found,
  output logic [$clog2(NODES)-1:0] winner_idx,
  output logic [MW-1:0]            winner_m,
  output logic                     rd_en,
  output int                       rd_class,
  output logic [$clog2(NODES)-1:0] rd_idx,
  input  node_vector_T             rd_w,
  input  logic [MW-1:0]            rd_m,
  input  logic                     rd_occupied,
  output node_vector_T             x,
  output int                       c,
  output logic                     key_response,
  output logic                     assoc_learning_start,
  input  logic                     assoc_learning_done,
`ifdef GAM_ASSOC_TIMEOUT_EN
  output logic                     timeout_err,
`endif
  output scan_state_T              dbg_state
);

  localparam int IW = $clog2(NODES);
  localparam int CW = (CLASSES > 1) ? $clog2(CLASSES) : 1;

  scan_state_T   state;
  logic [CW-1:0] class_q;
  logic          rd_vld_q;   // read data is on rd_* this cycle
  logic [IW-1:0] rd_idx_q;   // slot that the current read data belongs to
  logic          accept;

  logic          sel_valid;
  logic [IW-1:0] sel_idx;
  logic [MW-1:0] sel_m;
  node_vector_T  sel_w;

  // Node storage only holds CLASSES classes; upper class bits are dropped.
  logic unused_class_hi;
  assign unused_class_hi = ^scan_class;

`ifdef GAM_ASSOC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
`endif

  assign accept    = (state == S_IDLE) && scan_start;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;
  assign c         = int'({{(32-CW){1'b0}}, class_q});
  assign rd_class  = c;

  gam_max_m_select #(
    .NODES (NODES),
    .MW    (MW)
  ) u_sel (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .sample    (rd_vld_q),
    .occupied  (rd_occupied),
    .m         (rd_m),
    .w         (rd_w),
    .idx       (rd_idx_q),
    .nxt_valid (sel_valid),
    .nxt_idx   (sel_idx),
    .nxt_m     (sel_m),
    .nxt_w     (sel_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= S_IDLE;
      class_q              <= '0;
      key_response         <= 1'b0;
      rd_en                <= 1'b0;
      rd_idx               <= '0;
      rd_vld_q             <= 1'b0;
      rd_idx_q             <= '0;
      scan_done            <= 1'b0;
      found                <= 1'b0;
      winner_idx           <= '0;
      winner_m             <= '0;
      x                    <= '0;
      assoc_learning_start <= 1'b0;
`ifdef GAM_ASSOC_TIMEOUT_EN
      to_cnt               <= '0;
      timeout_err          <= 1'b0;
`endif
    end else begin
      scan_done            <= 1'b0;
      assoc_learning_start <= 1'b0;
      rd_vld_q             <= rd_en;
      rd_idx_q             <= rd_idx;
      case (state)
        S_IDLE: begin
          if (scan_start) begin
            state        <= S_SCAN;
            class_q      <= scan_class[CW-1:0];
            key_response <= scan_key_response;
            rd_en        <= 1'b1;
            rd_idx       <= '0;
`ifdef GAM_ASSOC_TIMEOUT_EN
            timeout_err  <= 1'b0;
`endif
          end
        end
        S_SCAN: begin
          if (rd_idx == IW'(NODES - 1)) begin
            rd_en <= 1'b0;
            state <= S_DRAIN;
          end else begin
            rd_idx <= rd_idx + 1'b1;
          end
        end
        S_DRAIN: begin
          // sel_* already includes the last slot returned this cycle.
          found      <= sel_valid;
          winner_idx <= sel_idx;
          winner_m   <= sel_m;
          x          <= sel_w;
          if (sel_valid) begin
            state                <= S_HANDOFF;
            assoc_learning_start <= 1'b1;
          end else begin
            state     <= S_DONE;
            scan_done <= 1'b1;
          end
        end
        S_HANDOFF: begin
          state <= S_WAIT;
`ifdef GAM_ASSOC_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (assoc_learning_done) begin
            state     <= S_DONE;
            scan_done <= 1'b1;
          end
`ifdef GAM_ASSOC_TIMEOUT_EN
          else if (to_cnt == TW'(TIMEOUT - 1)) begin
            state       <= S_DONE;
            scan_done   <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gam_class_winner_scan.sv
module tb_gam_class_winner_scan;
  import GAM_package::*;

  localparam int NODES = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         scan_start = 1'b0;
  int           scan_class = 0;
  logic         scan_key_response = 1'b0;
  logic         busy, scan_done, found;
  logic [1:0]   winner_idx;
  logic [7:0]   winner_m;
  logic         rd_en;
  int           rd_class;
  logic [1:0]   rd_idx;
  node_vector_T rd_w = '0;
  logic [7:0]   rd_m = '0;
  logic         rd_occupied = 1'b0;
  node_vector_T x;
  int           c;
  logic         key_response, assoc_learning_start;
  logic         assoc_learning_done = 1'b0;
  scan_state_T  dbg_state;
`ifdef GAM_ASSOC_TIMEOUT_EN
  logic         timeout_err;
`endif

  gam_class_winner_scan #(
    .NODES   (NODES),
    .CLASSES (16),
    .MW      (8)
`ifdef GAM_ASSOC_TIMEOUT_EN
    , .TIMEOUT (8)
`endif
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .scan_start           (scan_start),
    .scan_class           (scan_class),
    .scan_key_response    (scan_key_response),
    .busy                 (busy),
    .scan_done            (scan_done),
    .found                (found),
    .winner_idx           (winner_idx),
    .winner_m             (winner_m),
    .rd_en                (rd_en),
    .rd_class             (rd_class),
    .rd_idx               (rd_idx),
    .rd_w                 (rd_w),
    .rd_m                 (rd_m),
    .rd_occupied          (rd_occupied),
    .x                    (x),
    .c                    (c),
    .key_response         (key_response),
    .assoc_learning_start (assoc_learning_start),
    .assoc_learning_done  (assoc_learning_done),
`ifdef GAM_ASSOC_TIMEOUT_EN
    .timeout_err          (timeout_err),
`endif
    .dbg_state            (dbg_state)
  );

  // ---------------- node storage model (1-cycle read) ----------------
  logic [31:0] mem_w [16][NODES];
  logic [7:0]  mem_m [16][NODES];
  logic        mem_o [16][NODES];

  always @(posedge clk) begin
    if (rd_en) begin
      rd_w        <= mem_w[rd_class[3:0]][rd_idx];
      rd_m        <= mem_m[rd_class[3:0]][rd_idx];
      rd_occupied <= mem_o[rd_class[3:0]][rd_idx];
    end
  end

  // Every class gets occupied random-M filler; the scanned class is then
  // overwritten, so reading the wrong class changes the result.
  task automatic load_mem(input int cls, input logic [3:0][7:0] m, input logic [3:0] occ);
    for (int k2 = 0; k2 < 16; k2++) begin
      for (int s = 0; s < NODES; s++) begin
        mem_w[k2][s] = 32'hC0DE_0000 | (k2 << 4) | s;
        mem_m[k2][s] = 8'($urandom_range(0, 255));
        mem_o[k2][s] = 1'b1;
      end
    end
    for (int s = 0; s < NODES; s++) begin
      mem_m[cls][s] = m[s];
      mem_o[cls][s] = occ[s];
    end
  endtask

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  int          start_cyc, done_cyc, n_start, n_done, first_rd, n_rd;
  int          cap_c, cap_found_c;
  logic        cap_kr, cap_found, cap_to;
  logic [1:0]  cap_idx;
  logic [7:0]  cap_m;
  logic [31:0] cap_x;

  // Leaves the bench at the negedge of cycle t+1 (t = edge that samples start).
  task automatic start_req(input int cls, input logic kr);
    @(negedge clk);
    scan_start = 1'b1;
    scan_class = cls;
    scan_key_response = kr;
    @(negedge clk);
    scan_start = 1'b0;
  endtask

  // Observes 24 cycles (cycle index relative to t); optionally answers
  // assoc_learning_start with done in the first WAIT cycle, and optionally
  // pulses a second scan_start (class 9) in cycle extra.
  task automatic run_req(input int cls, input logic kr, input bit auto_done, input int extra);
    logic prev_start;
    start_req(cls, kr);
    start_cyc = -1; done_cyc = -1; n_start = 0; n_done = 0;
    first_rd = -1; n_rd = 0; prev_start = 1'b0; cap_to = 1'b0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      assoc_learning_done = auto_done && prev_start;
      if (cyc == extra) begin
        scan_start = 1'b1;
        scan_class = 9;
      end else begin
        scan_start = 1'b0;
      end
      if (rd_en) begin
        n_rd++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (assoc_learning_start) begin
        n_start++;
        if (start_cyc < 0) begin
          start_cyc = cyc; cap_c = c; cap_kr = key_response; cap_x = x;
        end
      end
      if (scan_done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = cyc; cap_found = found; cap_idx = winner_idx;
          cap_m = winner_m; cap_found_c = c;
`ifdef GAM_ASSOC_TIMEOUT_EN
          cap_to = timeout_err;
`endif
        end
      end
      prev_start = assoc_learning_start;
      @(negedge clk);
    end
    scan_start = 1'b0;
    assoc_learning_done = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    int              cls;
    logic            kr;
    logic [3:0][7:0] m;      // m[k] is slot k
    logic [3:0]      occ;    // occ[k] is slot k
    int              extra;  // cycle of an ignored second scan_start, 0 = none
    logic            exp_found;
    logic [1:0]      exp_idx;
    logic [7:0]      exp_m;
    logic [31:0]     exp_x;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // M {2,7,5,7}: first 7 wins (index 1)
    vecs[0] = '{cls: 3,  kr: 1'b0, m: 32'h07050702, occ: 4'b1111, extra: 0,
                exp_found: 1'b1, exp_idx: 2'd1, exp_m: 8'd7,   exp_x: 32'hC0DE_0031};
    // empty class
    vecs[1] = '{cls: 5,  kr: 1'b0, m: 32'h09090909, occ: 4'b0000, extra: 0,
                exp_found: 1'b0, exp_idx: 2'd0, exp_m: 8'd0,   exp_x: 32'h0};
    // only slot 3 occupied with M=0, response phase
    vecs[2] = '{cls: 7,  kr: 1'b1, m: 32'h00000000, occ: 4'b1000, extra: 0,
                exp_found: 1'b1, exp_idx: 2'd3, exp_m: 8'd0,   exp_x: 32'hC0DE_0073};
    // unoccupied slot 2 (255) ignored, slot 3 255 beats 200 unsigned
    vecs[3] = '{cls: 2,  kr: 1'b1, m: 32'hFFFF09C8, occ: 4'b1011, extra: 0,
                exp_found: 1'b1, exp_idx: 2'd3, exp_m: 8'd255, exp_x: 32'hC0DE_0023};
    // all equal: lowest index
    vecs[4] = '{cls: 15, kr: 1'b0, m: 32'h04040404, occ: 4'b1111, extra: 0,
                exp_found: 1'b1, exp_idx: 2'd0, exp_m: 8'd4,   exp_x: 32'hC0DE_00F0};
    // slots 1,2 occupied at M=0: first occupied wins
    vecs[5] = '{cls: 1,  kr: 1'b0, m: 32'h00000000, occ: 4'b0110, extra: 0,
                exp_found: 1'b1, exp_idx: 2'd1, exp_m: 8'd0,   exp_x: 32'hC0DE_0011};
    // second scan_start during SCAN is ignored
    vecs[6] = '{cls: 3,  kr: 1'b0, m: 32'h07050702, occ: 4'b1111, extra: 3,
                exp_found: 1'b1, exp_idx: 2'd1, exp_m: 8'd7,   exp_x: 32'hC0DE_0031};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_found", found, 0);
    check("rst_assoc_start", assoc_learning_start, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_key_response", key_response, 0);
    check("rst_winner_idx", winner_idx, 0);
    check("rst_winner_m", winner_m, 0);
    check("rst_rd_idx", rd_idx, 0);
    check("rst_x", x, 0);
    check("rst_c", c, 0);
    check("rst_rd_class", rd_class, 0);
`ifdef GAM_ASSOC_TIMEOUT_EN
    check("rst_timeout_err", timeout_err, 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      load_mem(vecs[i].cls, vecs[i].m, vecs[i].occ);
      run_req(vecs[i].cls, vecs[i].kr, 1'b1, vecs[i].extra);
      check($sformatf("v%0d_first_rd", i), first_rd, 1);
      check($sformatf("v%0d_n_rd", i), n_rd, NODES);
      check($sformatf("v%0d_n_done", i), n_done, 1);
      check($sformatf("v%0d_found", i), cap_found, vecs[i].exp_found);
      check($sformatf("v%0d_done_c", i), cap_found_c, vecs[i].cls);
      check($sformatf("v%0d_busy_after", i), busy, 0);
      if (vecs[i].exp_found) begin
        check($sformatf("v%0d_winner_idx", i), cap_idx, vecs[i].exp_idx);
        check($sformatf("v%0d_winner_m", i), cap_m, vecs[i].exp_m);
        check($sformatf("v%0d_n_start", i), n_start, 1);
        check($sformatf("v%0d_start_cyc", i), start_cyc, NODES + 2);
        check($sformatf("v%0d_done_cyc", i), done_cyc, NODES + 4);
        check($sformatf("v%0d_c", i), cap_c, vecs[i].cls);
        check($sformatf("v%0d_key_response", i), cap_kr, vecs[i].kr);
        check($sformatf("v%0d_x", i), cap_x, vecs[i].exp_x);
      end else begin
        check($sformatf("v%0d_n_start", i), n_start, 0);
        check($sformatf("v%0d_done_cyc", i), done_cyc, NODES + 2);
      end
    end

    // reset while waiting for the associative layer
    begin
      int n_pulse;
      load_mem(3, 32'h07050702, 4'b1111);
      start_req(3, 1'b0);                     // cycle 1
      repeat (NODES + 1) @(negedge clk);      // cycle 6: HANDOFF
      check("rstw_start", assoc_learning_start, 1);
      @(negedge clk);                         // cycle 7: WAIT
      check("rstw_busy_wait", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rstw_busy", busy, 0);
      check("rstw_found", found, 0);
      check("rstw_x", x, 0);
      check("rstw_c", c, 0);
      check("rstw_winner_idx", winner_idx, 0);
      assoc_learning_done = 1'b1;
      n_pulse = 0;
      repeat (8) begin
        if (scan_done || assoc_learning_start || busy) n_pulse++;
        @(negedge clk);
      end
      assoc_learning_done = 1'b0;
      check("rstw_no_pulse", n_pulse, 0);
    end

`ifdef GAM_ASSOC_TIMEOUT_EN
    // done never comes: give up after 8 WAIT cycles (WAIT starts at t+7)
    load_mem(3, 32'h07050702, 4'b1111);
    run_req(3, 1'b0, 1'b0, 0);
    check("to_n_start", n_start, 1);
    check("to_done_cyc", done_cyc, NODES + 3 + 8);
    check("to_err", cap_to, 1);
    check("to_n_done", n_done, 1);
    // next accepted request clears the error
    load_mem(15, 32'h04040404, 4'b1111);
    run_req(15, 1'b0, 1'b1, 0);
    check("to_clear_done_cyc", done_cyc, NODES + 4);
    check("to_clear_err", cap_to, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gam_class_winner_scan.md
# gam_class_winner_scan

Memory-layer stage directly upstream of the associative layer. On request it scans every node slot of one class in memory-layer node storage and selects the occupied node with the largest learning count M. It presents that node's weight vector as `x`, and the class as `c`, to the associative layer, then runs the `assoc_learning_start`/`assoc_learning_done` handshake on the key/response phase's behalf.

## Interface
- `NODES`, 16: node slots per class; ≥2.
- `CLASSES`, 16: number of classes.
- `MW`, 8: width of learning count M.
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `scan_start` in 1: request; sampled only in IDLE.
- `scan_class` in int: class to scan; captured with `scan_start`.
- `scan_key_response` in 1: phase, 0 key / 1 response; captured with `scan_start`.
- `busy` out 1: high in every state except IDLE.
- `scan_done` out 1: one-cycle pulse when the request completes.
- `found` out 1: valid with `scan_done`; 1 means an occupied node existed.
- `winner_idx` out $clog2(NODES): slot index of the winner.
- `winner_m` out MW: M of the winner.
- `rd_en` out 1: node-storage read strobe.
- `rd_class` out int: read class.
- `rd_idx` out $clog2(NODES): read slot.
- `rd_w` in node_vector_T: slot weight, one cycle after `rd_en`.
- `rd_m` in MW: slot M, one cycle after `rd_en`.
- `rd_occupied` in 1: slot holds a node, one cycle after `rd_en`.
- `x` out node_vector_T: winner weight, held stable from HANDOFF through WAIT.
- `c` out int: captured class.
- `key_response` out 1: captured phase.
- `assoc_learning_start` out 1: one-cycle pulse.
- `assoc_learning_done` in 1: completion from the associative layer.

## Operation
- States:
  - IDLE: `scan_start` → SCAN; capture class and phase; clear the best-so-far registers (`best_valid`=0).
  - SCAN: issue `rd_en`=1 with `rd_idx` stepping 0..NODES-1, one slot per cycle. After slot NODES-1 → DRAIN.
  - DRAIN: accept the last returned slot, no read issued. If `best_valid` → HANDOFF, else → DONE with `found`=0.
  - HANDOFF: `assoc_learning_start`=1 → WAIT.
  - WAIT: on `assoc_learning_done`=1 → DONE.
  - DONE: `scan_done`=1 → IDLE.
- Compare rule, applied on each returned slot:
  - A slot replaces the best only if `rd_occupied`=1 and either `best_valid`=0 or `rd_m` > best M.
  - Strictly greater, so on a tie the lowest index wins.
  - The compare is unsigned on MW bits.
- `x`, `winner_idx`, `winner_m` and `found` update only at the DRAIN→next transition and hold until the next request's DRAIN.
- `c` and `key_response` are held from capture.
- `scan_start` while `busy` is ignored and not queued.
- `assoc_learning_done` is sampled only in WAIT. A level high during HANDOFF is ignored.
- The empty class (no occupied slot) never pulses `assoc_learning_start`.

## Timing
- `scan_start` sampled at edge t. Reads issue in cycles t+1..t+NODES. Data for slot k returns in cycle t+2+k.
- DRAIN at t+NODES+1, HANDOFF (`assoc_learning_start` high) at t+NODES+2.
- With `assoc_learning_done` high in the first WAIT cycle, `scan_done` is at t+NODES+4.
- Empty class: `scan_done` at t+NODES+2.
- Reset values:
  - `busy`, `scan_done`, `found`, `assoc_learning_start`, `rd_en`, `key_response` = 0.
  - `winner_idx`, `winner_m`, `rd_idx` = 0.
  - `x` = all zeros.
  - `c`, `rd_class` = 0.
- `rst` in any state forces IDLE next cycle with all outputs at reset values. No start or done pulse is emitted for the aborted request.

## Configuration
- `GAM_ASSOC_TIMEOUT_EN` defined:
  - Adds parameter `TIMEOUT` (default 64) and output `timeout_err` (1 bit, reset 0).
  - If WAIT lasts `TIMEOUT` cycles without `assoc_learning_done`, go to DONE. `scan_done`=1 and `timeout_err`=1 in that same cycle.
  - `timeout_err` clears on the next accepted `scan_start`.
- Undefined: no counter, no port. WAIT holds indefinitely.

## Structure
- GAM_package:
  - Add `mem_node_rd_T` (w: node_vector_T, m, occupied).
  - Add the scan state enum.
  - Add the `MW` default constant.
  - Reuse the existing `node_vector_T`.
- One sub-module: `gam_max_m_select`, the registered best-so-far compare/update with tie rule and clear.
- The FSM and read addressing stay in the top.

## Test plan
- NODES=4, class 3, M={2,7,5,7}, all occupied, key phase:
  - `winner_idx`=1, `winner_m`=7.
  - `assoc_learning_start` at t+6 with `key_response`=0, `c`=3, `x`=slot-1 W.
- All slots unoccupied:
  - `found`=0.
  - No `assoc_learning_start`.
  - `scan_done` at t+6.
- Only slot 3 occupied, M=0, response phase: `found`=1, `winner_idx`=3, `key_response`=1.
- `scan_start` pulsed again during SCAN: ignored. Exactly one `scan_done`, and the first request's class is reported.
- `rst` asserted in WAIT: next cycle IDLE, `busy`=0. A late `assoc_learning_done` causes no `scan_done`.
- With `GAM_ASSOC_TIMEOUT_EN`, TIMEOUT=8, done never asserted: `scan_done` and `timeout_err` both high 8 cycles after entering WAIT.
